iex_div: RTL

- Iterative RV32M divide/remainder unit in the execute stage.
- Produces the execute-stage hazard that the pipeline auxiliary controller consumes. It holds the divide instruction in execute, freezing fetch and decode, until the result is ready.
- Consumes the controller's pipeline stall and the trap/jump kill, so it is the hazard-producing end of the controller interface.
- Radix-2 restoring algorithm: one quotient bit per cycle, with a fast path for divide-by-zero and signed overflow.

---
 rtl/iex_div_pkg.sv | 26 ++
 rtl/iex_div_core.sv | 72 +++++++
 rtl/iex_div.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/iex_div_pkg.sv
// Shared opcode and state encodings for the execute-stage divide unit.
// Opcode bit 0 clear means signed, bit 1 set means a remainder is wanted.
package iex_div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/iex_div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle for XLEN cycles.
// The quotient is shifted into the low end of the dividend register as it is consumed.
module iex_div_core #(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dsr_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;

    logic [XLEN-1:0] rem_sh;
    logic [XLEN:0]   trial;
    logic            trial_ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;

    // The partial remainder stays below the divisor, so its top bit can only be
    // set after the final shift; dropping it on earlier shifts loses nothing.
    always_comb begin
        rem_sh   = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
        trial    = {1'b0, rem_sh} - {1'b0, dsr_q};
        trial_ge = ~trial[XLEN];
        rem_nx   = trial_ge ? trial[XLEN-1:0] : rem_sh;
        quo_nx   = {dvd_q[XLEN-2:0], trial_ge};
    end

    // Outputs show the values after the iteration in progress, so the owner can
    // capture the final result on the same edge that finishes the last bit.
    assign done      = busy_q && (cnt_q == CW'(XLEN - 1));
    assign quotient  = quo_nx;
    assign remainder = rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (kill) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            dvd_q  <= dividend;
            dsr_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_nx;
            dvd_q <= quo_nx;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iex_div.sv
// RV32M DIV/DIVU/REM/REMU unit in execute: holds the pipeline via div2ac_hazard
// while the iterative core runs, then presents a registered result for one cycle.
module iex_div
    import iex_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_rs1,
    input  logic [XLEN-1:0] div_rs2,
    input  logic            ac2div_stall,
    input  logic            div_kill,
    output logic            div2ac_hazard,
    output logic            div_out_valid,
    output logic [XLEN-1:0] div_result,
    output logic            div_busy
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q;
    div_state_e      state_d;
    logic            is_rem_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [XLEN-1:0] result_q;

    logic            signed_op;
    logic            div_by_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] abs_rs1;
    logic [XLEN-1:0] abs_rs2;
    logic            accept;
    logic            core_start;
    logic            core_done;
    logic [XLEN-1:0] core_quo;
    logic [XLEN-1:0] core_rem;
    logic [XLEN-1:0] fixed_res;

    always_comb begin
        signed_op   = op_is_signed(div_op);
        div_by_zero = (div_rs2 == '0);
        overflow    = signed_op && (div_rs1 == MIN_NEG) && (div_rs2 == '1);
        special     = div_by_zero || overflow;
        if (div_by_zero) begin
            special_res = op_is_rem(div_op) ? div_rs1 : '1;
        end else begin
            special_res = op_is_rem(div_op) ? '0 : MIN_NEG;
        end
        abs_rs1    = (signed_op && div_rs1[XLEN-1]) ? -div_rs1 : div_rs1;
        abs_rs2    = (signed_op && div_rs2[XLEN-1]) ? -div_rs2 : div_rs2;
        accept     = (state_q == ST_IDLE) && div_valid && !div_kill;
        core_start = accept && !special;
    end

    iex_div_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .kill      (div_kill),
        .dividend  (abs_rs1),
        .divisor   (abs_rs2),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    always_comb begin
        if (is_rem_q) begin
            fixed_res = r_neg_q ? -core_rem : core_rem;
        end else begin
            fixed_res = q_neg_q ? -core_quo : core_quo;
        end
    end

    // DONE never raises the hazard, so the instruction leaves execute exactly
    // once unless the downstream stall keeps the whole pipeline frozen.
    always_comb begin
        state_d       = state_q;
        div2ac_hazard = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div2ac_hazard = div_valid;
                if (accept) begin
                    state_d = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                div2ac_hazard = 1'b1;
                if (core_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!ac2div_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (div_kill) begin
            state_d = ST_IDLE;
            if (state_q != ST_IDLE) begin
                div2ac_hazard = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_rem_q <= op_is_rem(div_op);
                q_neg_q  <= signed_op && (div_rs1[XLEN-1] ^ div_rs2[XLEN-1]);
                r_neg_q  <= signed_op && div_rs1[XLEN-1];
                if (special) begin
                    result_q <= special_res;
                end
            end
            if ((state_q == ST_CALC) && core_done && !div_kill) begin
                result_q <= fixed_res;
            end
        end
    end

    assign div_out_valid = (state_q == ST_DONE);
    assign div_result    = result_q;
    assign div_busy      = (state_q != ST_IDLE);

endmodule
